// File: rtl/randn_lfg_pkg.sv
// Shared types and helpers for the lagged-Fibonacci noise generator.
//   state_e          : controller states INIT (buffer fill), WARM (discard), RUN
//   GOLDEN           : odd 32-bit constant used to spread NUMBER across the seed space
//   xorshift32_step  : one xorshift32 update (13, 17, 5)
//   seed_mix         : per-instance seed scrambling; never returns the xorshift
//                      fixed point 0
package randn_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [31:0] seed_mix(input logic [31:0] s, input logic [31:0] number);
        logic [31:0] m;
        m = s ^ (number * GOLDEN);
        return (m == '0) ? 32'h0000_0001 : m;
    endfunction

endpackage

// File: rtl/randn_lfg_if.sv
// Control/data bundle of randn_lfg.
//   en, seed_load, seed_in      : requests from the consumer (master)
//   ready                       : generator is in RUN
//   u_out / u_valid             : signed uniform word and its one-cycle strobe
//   g_out / g_valid             : signed NSUM-sample sum and its one-cycle strobe
// GW must equal WIDTH + $clog2(NSUM) of the attached generator.
interface randn_lfg_if #(
    parameter int WIDTH = 8,
    parameter int GW    = 8
);
    logic                    en;
    logic                    seed_load;
    logic [31:0]             seed_in;
    logic                    ready;
    logic signed [WIDTH-1:0] u_out;
    logic                    u_valid;
    logic signed [GW-1:0]    g_out;
    logic                    g_valid;

    modport master (
        output en, seed_load, seed_in,
        input  ready, u_out, u_valid, g_out, g_valid
    );

    modport slave (
        input  en, seed_load, seed_in,
        output ready, u_out, u_valid, g_out, g_valid
    );
endinterface

// File: rtl/randn_seed_gen.sv
// xorshift32 seed source for the LFG buffer fill.
//   clk, reset : clock, synchronous active-high reset (loads RESET_VAL)
//   load       : replace the state with load_val (dominates step)
//   load_val   : already-mixed seed
//   step       : advance one xorshift32 step
//   rnd_o      : low OUT_W bits of the *next* state, i.e. the word produced by
//                the step taken on this edge
module randn_seed_gen
    import randn_pkg::*;
#(
    parameter int          OUT_W     = 8,
    parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [31:0]      load_val,
    input  logic             step,
    output logic [OUT_W-1:0] rnd_o
);
    logic [31:0] x_q, x_d, x_next;

    always_comb begin
        x_next = xorshift32_step(x_q);
        x_d    = x_q;
        if (load) begin
            x_d = load_val;
        end else if (step) begin
            x_d = x_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= RESET_VAL;
        end else begin
            x_q <= x_d;
        end
    end

    assign rnd_o = x_next[OUT_W-1:0];
endmodule

// File: rtl/randn_lfg.sv
// Lagged-Fibonacci noise generator: X[n] = X[n-LAG_LONG] -/+ X[n-LAG_SHORT] mod 2^WIDTH,
// self-seeded from xorshift32, with an NSUM-sample accumulator for a CLT Gaussian.
//   clk   : clock
//   reset : synchronous active-high reset (dominates seed_load and en)
//   bus   : randn_lfg_if slave (en, seed_load, seed_in, ready, u_out/u_valid, g_out/g_valid)
module randn_lfg
    import randn_pkg::*;
#(
    parameter int          NUMBER    = 0,
    parameter int          WIDTH     = 8,
    parameter int          LAG_LONG  = 55,
    parameter int          LAG_SHORT = 24,
    parameter int          ADD_MODE  = 0,
    parameter logic [31:0] SEED      = 32'h1234_5678,
    parameter int          WARMUP    = 110,
    parameter int          NSUM      = 1
) (
    input logic       clk,
    input logic       reset,
    randn_lfg_if.slave bus
);
    localparam int GW        = WIDTH + $clog2(NSUM);
    localparam int PW        = (LAG_LONG > 1) ? $clog2(LAG_LONG) : 1;
    localparam int WW        = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int SW        = (NSUM > 1) ? $clog2(NSUM) : 1;
    localparam int SHORT_OFF = LAG_LONG - LAG_SHORT;
    localparam logic [PW-1:0] LAST_IDX  = PW'(LAG_LONG - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [SW-1:0] SUM_LAST  = SW'(NSUM - 1);

    if (LAG_SHORT < 1 || LAG_SHORT >= LAG_LONG) begin : g_bad_lag
        $fatal(1, "randn_lfg: LAG_SHORT must satisfy 1 <= LAG_SHORT < LAG_LONG");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "randn_lfg: WIDTH must be in 2..32");
    end
    if (NSUM < 1) begin : g_bad_nsum
        $fatal(1, "randn_lfg: NSUM must be >= 1");
    end

    state_e                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d, fill_q, fill_d, ptr_inc, short_idx;
    logic [WW-1:0]           warm_q, warm_d;
    logic [SW-1:0]           sum_cnt_q, sum_cnt_d;
    logic signed [GW-1:0]    acc_q, acc_d, g_out_q, g_out_d, acc_sum;
    logic signed [WIDTH-1:0] u_out_q, u_out_d;
    logic                    u_valid_q, u_valid_d, g_valid_q, g_valid_d;

    logic [WIDTH-1:0]        mem_q [LAG_LONG];
    logic                    mem_we;
    logic [PW-1:0]           mem_wa;
    logic [WIDTH-1:0]        mem_wd, step_word, seed_word, seed_rnd;
    logic                    seed_step;

    randn_seed_gen #(
        .OUT_W    (WIDTH),
        .RESET_VAL(seed_mix(SEED, 32'(NUMBER)))
    ) u_seed_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (bus.seed_load),
        .load_val(seed_mix(bus.seed_in, 32'(NUMBER))),
        .step    (seed_step),
        .rnd_o   (seed_rnd)
    );

    // Circular-buffer addressing: ptr is X[n-LAG_LONG], short tap sits LAG_LONG-LAG_SHORT ahead.
    always_comb begin
        ptr_inc = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
        if (int'(ptr_q) + SHORT_OFF >= LAG_LONG) begin
            short_idx = PW'(int'(ptr_q) + SHORT_OFF - LAG_LONG);
        end else begin
            short_idx = PW'(int'(ptr_q) + SHORT_OFF);
        end
        step_word = (ADD_MODE != 0) ? mem_q[ptr_q] + mem_q[short_idx]
                                    : mem_q[ptr_q] - mem_q[short_idx];
        seed_word = seed_rnd;
        // An odd word in the fill guarantees the maximal-period orbit.
        if (fill_q == '0) begin
            seed_word[0] = 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (fill_q == LAST_IDX) state_d = (WARMUP == 0) ? RUN : WARM;
            WARM:    if (warm_q == WARM_LAST) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
        if (bus.seed_load) begin
            state_d = INIT;
        end
    end

    // FSM outputs and datapath
    always_comb begin
        ptr_d     = ptr_q;
        fill_d    = fill_q;
        warm_d    = warm_q;
        sum_cnt_d = sum_cnt_q;
        acc_d     = acc_q;
        u_out_d   = u_out_q;
        u_valid_d = 1'b0;
        g_out_d   = g_out_q;
        g_valid_d = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = ptr_q;
        mem_wd    = step_word;
        seed_step = 1'b0;
        acc_sum   = acc_q + GW'(u_out_q);

        unique case (state_q)
            INIT: begin
                seed_step = 1'b1;
                mem_we    = 1'b1;
                mem_wa    = fill_q;
                mem_wd    = seed_word;
                fill_d    = (fill_q == LAST_IDX) ? '0 : fill_q + 1'b1;
            end
            WARM: begin
                mem_we = 1'b1;
                ptr_d  = ptr_inc;
                warm_d = (warm_q == WARM_LAST) ? '0 : warm_q + 1'b1;
            end
            RUN: begin
                if (bus.en) begin
                    mem_we    = 1'b1;
                    ptr_d     = ptr_inc;
                    u_out_d   = step_word;
                    u_valid_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Sum the word that is on u_out this cycle; publish on the NSUM-th one.
        if (u_valid_q) begin
            if (sum_cnt_q == SUM_LAST) begin
                g_out_d   = acc_sum;
                g_valid_d = 1'b1;
                acc_d     = '0;
                sum_cnt_d = '0;
            end else begin
                acc_d     = acc_sum;
                sum_cnt_d = sum_cnt_q + 1'b1;
            end
        end

        // Reseed restarts the fill from slot 0 so the stream replays exactly.
        if (bus.seed_load) begin
            ptr_d     = '0;
            fill_d    = '0;
            warm_d    = '0;
            sum_cnt_d = '0;
            acc_d     = '0;
            u_out_d   = u_out_q;
            g_out_d   = g_out_q;
            u_valid_d = 1'b0;
            g_valid_d = 1'b0;
            mem_we    = 1'b0;
            seed_step = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            fill_q    <= '0;
            warm_q    <= '0;
            sum_cnt_q <= '0;
            acc_q     <= '0;
            u_out_q   <= '0;
            u_valid_q <= 1'b0;
            g_out_q   <= '0;
            g_valid_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            fill_q    <= fill_d;
            warm_q    <= warm_d;
            sum_cnt_q <= sum_cnt_d;
            acc_q     <= acc_d;
            u_out_q   <= u_out_d;
            u_valid_q <= u_valid_d;
            g_out_q   <= g_out_d;
            g_valid_q <= g_valid_d;
        end
    end

    // Register file has no reset: INIT overwrites every slot before it is read.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign bus.ready   = (state_q == RUN);
    assign bus.u_out   = u_out_q;
    assign bus.u_valid = u_valid_q;
    assign bus.g_out   = g_out_q;
    assign bus.g_valid = g_valid_q;
endmodule

// File: tb/tb_randn_lfg.sv
// Self-checking bench for randn_lfg: reset values, start-up latency, recurrence,
// Gaussian sums, enable gating, reseed replay, reset-vs-seed_load priority,
// instance separation and the additive/short-lag corner.
module tb_randn_lfg;
    localparam logic [31:0] DEF_SEED = 32'h1234_5678;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    randn_lfg_if #(.WIDTH(8),  .GW(8))  if0 ();
    randn_lfg_if #(.WIDTH(8),  .GW(10)) if4 ();
    randn_lfg_if #(.WIDTH(8),  .GW(8))  if1 ();
    randn_lfg_if #(.WIDTH(16), .GW(16)) ifa ();

    randn_lfg #(.NUMBER(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    randn_lfg #(.NUMBER(0), .NSUM(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    randn_lfg #(.NUMBER(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    randn_lfg #(.NUMBER(0), .WIDTH(16), .LAG_LONG(17), .LAG_SHORT(5), .ADD_MODE(1), .WARMUP(0))
        duta (.clk(clk), .reset(reset), .bus(ifa));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int unsigned ref_q[$];
    int unsigned r0[$], r1[$], ra[$];
    int unsigned u0[$], u4[$], u1[$], ua[$];
    int          g0[$], g4[$];
    int          uc0[$], gc0[$], uc4[$], gc4[$];

    typedef struct {
        logic en;
        logic exp_valid;
    } gate_vec_t;
    gate_vec_t gvec[8];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic int sx(input int unsigned v, input int w);
        return (v >= (32'd1 << (w - 1))) ? int'(v) - int'(32'd1 << w) : int'(v);
    endfunction

    // Sequence-form reference: history list X[0..], X[n] = X[n-ll] op X[n-ls].
    task automatic gen_ref(input int unsigned number, input int unsigned seed, input int width,
                           input int ll, input int ls, input int add, input int warm, input int n);
        int unsigned x, mask, v;
        int unsigned h[$];
        int m;
        mask = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 1);
        x = seed ^ (number * 32'h9E37_79B9);
        if (x == 0) x = 1;
        for (int i = 0; i < ll; i++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
            v = x & mask;
            if (i == 0) v = v | 1;
            h.push_back(v);
        end
        ref_q.delete();
        for (int k = 0; k < warm + n; k++) begin
            m = h.size();
            v = (add != 0) ? h[m - ll] + h[m - ls] : h[m - ll] - h[m - ls];
            v = v & mask;
            h.push_back(v);
            if (k >= warm) ref_q.push_back(v);
        end
    endtask

    // Count ticks until if0 shows u_valid; returns first ready/valid tick numbers.
    task automatic wait_first(output int first_r, output int first_v);
        int n;
        n = 0;
        first_r = -1;
        first_v = -1;
        while (first_v < 0 && n < 400) begin
            tick();
            n++;
            if (if0.ready && first_r < 0) first_r = n;
            if (if0.u_valid) first_v = n;
        end
    endtask

    // Checks that if0 (currently showing its first valid word) replays r0[0..cnt-1].
    task automatic check_replay(input string name, input int cnt);
        int bad;
        bad = 0;
        for (int i = 0; i < cnt; i++) begin
            if (i > 0) tick();
            if (!if0.u_valid || $unsigned(if0.u_out) != r0[i]) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        int first_r0, first_v0, first_ra, first_va, first_v4, first_v1;
        int bad, gaps, dd, md, fr, fv, exp_sum, idx;
        int unsigned last_u;
        int last_g;

        gvec[0] = '{1'b1, 1'b1};
        gvec[1] = '{1'b0, 1'b0};
        gvec[2] = '{1'b0, 1'b0};
        gvec[3] = '{1'b1, 1'b1};
        gvec[4] = '{1'b1, 1'b1};
        gvec[5] = '{1'b0, 1'b0};
        gvec[6] = '{1'b1, 1'b1};
        gvec[7] = '{1'b0, 1'b0};

        gen_ref(0, DEF_SEED, 8, 55, 24, 0, 110, 700);
        r0 = ref_q;
        gen_ref(1, DEF_SEED, 8, 55, 24, 0, 110, 16);
        r1 = ref_q;
        gen_ref(0, DEF_SEED, 16, 17, 5, 1, 0, 700);
        ra = ref_q;

        reset = 1'b1;
        if0.en = 1'b0; if0.seed_load = 1'b0; if0.seed_in = '0;
        if4.en = 1'b0; if4.seed_load = 1'b0; if4.seed_in = '0;
        if1.en = 1'b0; if1.seed_load = 1'b0; if1.seed_in = '0;
        ifa.en = 1'b0; ifa.seed_load = 1'b0; ifa.seed_in = '0;
        repeat (3) tick();

        check("rst_ready",   if0.ready,   0);
        check("rst_u_out",   if0.u_out,   0);
        check("rst_u_valid", if0.u_valid, 0);
        check("rst_g_out",   if0.g_out,   0);
        check("rst_g_valid", if0.g_valid, 0);
        check("rst_a_u_out", ifa.u_out,   0);

        // Release reset with en held high everywhere; tick n is the n-th edge after release.
        reset = 1'b0;
        if0.en = 1'b1; if4.en = 1'b1; if1.en = 1'b1; ifa.en = 1'b1;
        cyc = 0;
        first_r0 = -1; first_v0 = -1; first_ra = -1; first_va = -1; first_v4 = -1; first_v1 = -1;
        while (u0.size() < 500 && cyc < 1000) begin
            tick();
            if (if0.ready && first_r0 < 0) first_r0 = cyc;
            if (ifa.ready && first_ra < 0) first_ra = cyc;
            if (if0.u_valid) begin
                if (first_v0 < 0) first_v0 = cyc;
                u0.push_back($unsigned(if0.u_out));
                uc0.push_back(cyc);
            end
            if (if0.g_valid) begin g0.push_back(int'(if0.g_out)); gc0.push_back(cyc); end
            if (if4.u_valid) begin
                if (first_v4 < 0) first_v4 = cyc;
                u4.push_back($unsigned(if4.u_out));
                uc4.push_back(cyc);
            end
            if (if4.g_valid) begin g4.push_back(int'(if4.g_out)); gc4.push_back(cyc); end
            if (if1.u_valid) begin
                if (first_v1 < 0) first_v1 = cyc;
                u1.push_back($unsigned(if1.u_out));
            end
            if (ifa.u_valid) begin
                if (first_va < 0) first_va = cyc;
                ua.push_back($unsigned(ifa.u_out));
            end
        end
        if (u0.size() < 500) check("collect_timeout", u0.size(), 500);

        // ready is high just after edge 165, so edge 166 takes the first step.
        check("first_ready_dut0", first_r0, 165);
        check("first_valid_dut0", first_v0, 166);
        check("first_valid_nsum4", first_v4, 166);
        check("first_valid_num1", first_v1, 166);
        check("first_ready_add", first_ra, 17);
        check("first_valid_add", first_va, 18);

        gaps = 0;
        for (int k = 0; k < uc0.size(); k++) if (uc0[k] != 166 + k) gaps++;
        check("valid_every_cycle", gaps, 0);

        bad = 0;
        for (int k = 0; k < u0.size(); k++) if (u0[k] != r0[k]) bad++;
        check("stream_vs_model", bad, 0);
        check("stream_word0", u0[0], r0[0]);
        check("stream_word499", u0[499], r0[499]);

        bad = 0;
        for (int k = 55; k < u0.size(); k++)
            if (((u0[k - 55] - u0[k - 24]) & 32'hFF) != u0[k]) bad++;
        check("sub_recurrence", bad, 0);

        // NSUM = 1: g_out is the sign-extended u_out one cycle later.
        check("g1_count", g0.size(), 499);
        bad = 0;
        for (int k = 0; k < g0.size(); k++)
            if (g0[k] != sx(u0[k], 8) || gc0[k] != uc0[k] + 1) bad++;
        check("g1_follow_u", bad, 0);

        // NSUM = 4 instance shares NUMBER/SEED, so its uniform stream matches dut0.
        bad = 0;
        for (int k = 0; k < u4.size() && k < u0.size(); k++) if (u4[k] != u0[k]) bad++;
        check("nsum4_u_matches", bad, 0);
        check("g4_count", g4.size(), 124);
        bad = 0;
        for (int j = 0; j < g4.size(); j++) begin
            exp_sum = 0;
            for (int i = 0; i < 4; i++) exp_sum += sx(u4[4 * j + i], 8);
            if (g4[j] != exp_sum || gc4[j] != uc4[4 * j + 3] + 1) bad++;
        end
        check("g4_sums", bad, 0);
        check("g4_first", g4[0], sx(r0[0], 8) + sx(r0[1], 8) + sx(r0[2], 8) + sx(r0[3], 8));

        bad = 0;
        for (int k = 0; k < 16; k++) if (u1[k] != r1[k]) bad++;
        check("num1_vs_model", bad, 0);
        dd = 0;
        md = 0;
        for (int k = 0; k < 16; k++) begin
            if (u1[k] != u0[k]) dd++;
            if (r1[k] != r0[k]) md++;
        end
        check("inst_sep_diffs", dd, md);

        bad = 0;
        for (int k = 0; k < ua.size(); k++) if (ua[k] != ra[k]) bad++;
        check("add_vs_model", bad, 0);
        bad = 0;
        for (int k = 17; k < ua.size(); k++)
            if (((ua[k - 17] + ua[k - 5]) & 32'hFFFF) != ua[k]) bad++;
        check("add_recurrence", bad, 0);

        // Enable gating on dut0 only.
        if4.en = 1'b0; if1.en = 1'b0; ifa.en = 1'b0;
        idx = u0.size();
        last_u = u0[u0.size() - 1];
        for (int i = 0; i < 8; i++) begin
            if0.en = gvec[i].en;
            tick();
            check($sformatf("gate_valid_%0d", i), if0.u_valid, gvec[i].exp_valid);
            if (gvec[i].exp_valid) begin
                check($sformatf("gate_word_%0d", i), $unsigned(if0.u_out), r0[idx]);
                last_u = r0[idx];
                idx++;
            end else begin
                check($sformatf("gate_hold_%0d", i), $unsigned(if0.u_out), last_u);
            end
        end

        // Live reseed with the reset seed replays the post-reset stream.
        if0.en = 1'b1;
        tick();
        last_u = $unsigned(if0.u_out);
        last_g = int'(if0.g_out);
        if0.seed_in = DEF_SEED;
        if0.seed_load = 1'b1;
        tick();
        if0.seed_load = 1'b0;
        check("reseed_ready_low", if0.ready, 0);
        check("reseed_valid_low", if0.u_valid, 0);
        check("reseed_u_hold", $unsigned(if0.u_out), last_u);
        check("reseed_g_hold", int'(if0.g_out), last_g);
        wait_first(fr, fv);
        check("reseed_first_ready", fr, 165);
        check("reseed_first_valid", fv, 166);
        if (fv > 0) check_replay("reseed_replay", 20);

        // Reset and seed_load together: reset wins (SEED, not seed_in, outputs cleared).
        reset = 1'b1;
        if0.seed_in = 32'hDEAD_BEEF;
        if0.seed_load = 1'b1;
        tick();
        reset = 1'b0;
        if0.seed_load = 1'b0;
        check("rst_load_u_out", if0.u_out, 0);
        check("rst_load_g_out", if0.g_out, 0);
        check("rst_load_ready", if0.ready, 0);
        wait_first(fr, fv);
        check("rst_load_first_valid", fv, 166);
        if (fv > 0) check_replay("rst_load_replay", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
